// File: rtl/csr_trap_seq_if.sv
// Bundle of the execute-stage request/response signals and the CSR file port
// that surround the CSR/trap sequencer. Suffixes are from the sequencer's view.
interface csr_trap_seq_if #(
  parameter int XLEN = 32
);
  logic            ready_o;
  logic            csr_v_i;
  logic [1:0]      csr_op_i;
  logic [11:0]     csr_adr_i;
  logic [XLEN-1:0] csr_src_i;
  logic            csr_done_o;
  logic [XLEN-1:0] csr_rdata_o;
  logic            trap_v_i;
  logic [XLEN-1:0] trap_cause_i;
  logic [XLEN-1:0] trap_pc_i;
  logic [XLEN-1:0] trap_tval_i;
  logic            mret_v_i;
  logic            redirect_v_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            csr_write_v_o;
  logic [11:0]     csr_adr_wr_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic [11:0]     csr_adr_rd_o;
  logic [XLEN-1:0] csr_rdata_i;

  modport slave (
    output ready_o,
    input  csr_v_i, csr_op_i, csr_adr_i, csr_src_i,
    output csr_done_o, csr_rdata_o,
    input  trap_v_i, trap_cause_i, trap_pc_i, trap_tval_i,
    input  mret_v_i,
    output redirect_v_o, redirect_pc_o,
    output csr_write_v_o, csr_adr_wr_o, csr_wdata_o, csr_adr_rd_o,
    input  csr_rdata_i
  );

  modport master (
    input  ready_o,
    output csr_v_i, csr_op_i, csr_adr_i, csr_src_i,
    input  csr_done_o, csr_rdata_o,
    output trap_v_i, trap_cause_i, trap_pc_i, trap_tval_i,
    output mret_v_i,
    input  redirect_v_o, redirect_pc_o,
    input  csr_write_v_o, csr_adr_wr_o, csr_wdata_o, csr_adr_rd_o,
    output csr_rdata_i
  );
endinterface

// File: rtl/csr_trap_seq.sv
// CSR instruction read-modify-write, trap entry and MRET sequencer. Owns the
// single CSR file write port and read address, and issues fetch redirects.
module csr_trap_seq #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           reset,
  csr_trap_seq_if.slave bus
);

  localparam logic [1:0]  OP_RW = 2'b01;
  localparam logic [1:0]  OP_RS = 2'b10;
  localparam logic [1:0]  OP_RC = 2'b11;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  localparam logic [XLEN-1:0] ALIGN4 = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [3:0] {
    S_IDLE, S_CSR_WR, S_T_EPC, S_T_CAUSE, S_T_TVAL, S_T_STATUS,
    S_M_EPC, S_M_STATUS, S_REDIR
  } state_e;

  state_e state_q, state_d;

  logic [1:0]      op_q, op_d;
  logic [11:0]     adr_q, adr_d;
  logic [XLEN-1:0] src_q, src_d;
  logic [XLEN-1:0] old_q, old_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] tvec_q, tvec_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;

  logic idle, trap_acc, mret_acc, csr_acc, csr_wr_en;

  function automatic logic [XLEN-1:0] csr_modify(input logic [1:0]      op,
                                                 input logic [XLEN-1:0] old,
                                                 input logic [XLEN-1:0] src);
    logic [XLEN-1:0] r;
    case (op)
      OP_RW:   r = src;
      OP_RS:   r = old | src;
      OP_RC:   r = old & ~src;
      default: r = old;
    endcase
    return r;
  endfunction

  // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode as MPP.
  function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Vectored mode only offsets interrupts; the add wraps at XLEN bits.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tvec,
                                                  input logic [XLEN-1:0] cause);
    logic [XLEN-1:0] base;
    base = tvec & ALIGN4;
    if (tvec[1:0] == 2'b01 && cause[XLEN-1])
      base = base + {cause[XLEN-3:0], 2'b00};
    return base;
  endfunction

  assign idle      = (state_q == S_IDLE);
  assign trap_acc  = idle && bus.trap_v_i;
  assign mret_acc  = idle && !bus.trap_v_i && bus.mret_v_i;
  assign csr_acc   = idle && !bus.trap_v_i && !bus.mret_v_i && bus.csr_v_i;
  assign csr_wr_en = (op_q == OP_RW) ||
                     (((op_q == OP_RS) || (op_q == OP_RC)) && (src_q != '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (trap_acc)      state_d = S_T_EPC;
        else if (mret_acc) state_d = S_M_EPC;
        else if (csr_acc)  state_d = S_CSR_WR;
      end
      S_CSR_WR:   state_d = S_IDLE;
      S_T_EPC:    state_d = S_T_CAUSE;
      S_T_CAUSE:  state_d = S_T_TVAL;
      S_T_TVAL:   state_d = S_T_STATUS;
      S_T_STATUS: state_d = S_REDIR;
      S_M_EPC:    state_d = S_M_STATUS;
      S_M_STATUS: state_d = S_REDIR;
      S_REDIR:    state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Captured operands; the redirect target is registered one cycle ahead of REDIR.
  always_comb begin
    op_d       = op_q;
    adr_d      = adr_q;
    src_d      = src_q;
    old_d      = old_q;
    cause_d    = cause_q;
    pc_d       = pc_q;
    tval_d     = tval_q;
    tvec_d     = tvec_q;
    epc_d      = epc_q;
    redir_pc_d = redir_pc_q;
    if (csr_acc) begin
      op_d  = bus.csr_op_i;
      adr_d = bus.csr_adr_i;
      src_d = bus.csr_src_i;
      old_d = bus.csr_rdata_i;
    end
    if (trap_acc) begin
      cause_d = bus.trap_cause_i;
      pc_d    = bus.trap_pc_i;
      tval_d  = bus.trap_tval_i;
    end
    case (state_q)
      S_T_CAUSE:  tvec_d     = bus.csr_rdata_i;
      S_M_EPC:    epc_d      = bus.csr_rdata_i;
      S_T_STATUS: redir_pc_d = trap_target(tvec_q, cause_q);
      S_M_STATUS: redir_pc_d = epc_q;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= '0;
      adr_q      <= '0;
      src_q      <= '0;
      old_q      <= '0;
      cause_q    <= '0;
      pc_q       <= '0;
      tval_q     <= '0;
      tvec_q     <= '0;
      epc_q      <= '0;
      redir_pc_q <= '0;
    end else begin
      op_q       <= op_d;
      adr_q      <= adr_d;
      src_q      <= src_d;
      old_q      <= old_d;
      cause_q    <= cause_d;
      pc_q       <= pc_d;
      tval_q     <= tval_d;
      tvec_q     <= tvec_d;
      epc_q      <= epc_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  always_comb begin
    bus.ready_o       = idle;
    bus.csr_done_o    = 1'b0;
    bus.csr_rdata_o   = old_q;
    bus.redirect_v_o  = 1'b0;
    bus.redirect_pc_o = redir_pc_q;
    bus.csr_write_v_o = 1'b0;
    bus.csr_adr_wr_o  = '0;
    bus.csr_wdata_o   = '0;
    bus.csr_adr_rd_o  = '0;
    case (state_q)
      S_IDLE: bus.csr_adr_rd_o = bus.csr_adr_i;
      S_CSR_WR: begin
        bus.csr_done_o    = 1'b1;
        bus.csr_write_v_o = csr_wr_en;
        bus.csr_adr_wr_o  = adr_q;
        bus.csr_wdata_o   = csr_modify(op_q, old_q, src_q);
      end
      S_T_EPC: begin
        bus.csr_write_v_o = 1'b1;
        bus.csr_adr_wr_o  = A_MEPC;
        bus.csr_wdata_o   = pc_q & ALIGN4;
      end
      S_T_CAUSE: begin
        bus.csr_write_v_o = 1'b1;
        bus.csr_adr_wr_o  = A_MCAUSE;
        bus.csr_wdata_o   = cause_q;
        bus.csr_adr_rd_o  = A_MTVEC;
      end
      S_T_TVAL: begin
        bus.csr_write_v_o = 1'b1;
        bus.csr_adr_wr_o  = A_MTVAL;
        bus.csr_wdata_o   = tval_q;
      end
      S_T_STATUS: begin
        bus.csr_write_v_o = 1'b1;
        bus.csr_adr_wr_o  = A_MSTATUS;
        bus.csr_adr_rd_o  = A_MSTATUS;
        bus.csr_wdata_o   = trap_status(bus.csr_rdata_i);
      end
      S_M_EPC: bus.csr_adr_rd_o = A_MEPC;
      S_M_STATUS: begin
        bus.csr_write_v_o = 1'b1;
        bus.csr_adr_wr_o  = A_MSTATUS;
        bus.csr_adr_rd_o  = A_MSTATUS;
        bus.csr_wdata_o   = mret_status(bus.csr_rdata_i);
      end
      S_REDIR: bus.redirect_v_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Directed bench for csr_trap_seq: a small CSR file model sits on the write
// port / read address, and each step checks outputs against hand-derived values.
module tb_csr_trap_seq;
  localparam int XLEN = 32;
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [1:0]  OP_RW = 2'b01;
  localparam logic [1:0]  OP_RS = 2'b10;
  localparam logic [1:0]  OP_RC = 2'b11;

  logic clk = 1'b0;
  logic reset;
  logic clr;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  csr_trap_seq_if #(.XLEN(XLEN)) bus();

  csr_trap_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] m_status, m_tvec, m_scratch, m_epc, m_cause, m_tval;

  always_comb begin
    case (bus.csr_adr_rd_o)
      A_MSTATUS:  bus.csr_rdata_i = m_status;
      A_MTVEC:    bus.csr_rdata_i = m_tvec;
      A_MSCRATCH: bus.csr_rdata_i = m_scratch;
      A_MEPC:     bus.csr_rdata_i = m_epc;
      A_MCAUSE:   bus.csr_rdata_i = m_cause;
      A_MTVAL:    bus.csr_rdata_i = m_tval;
      default:    bus.csr_rdata_i = 32'h0;
    endcase
  end

  // The CSR file is not tied to the sequencer reset so writes survive it.
  always_ff @(posedge clk) begin
    if (clr) begin
      m_status <= '0; m_tvec <= '0; m_scratch <= '0;
      m_epc    <= '0; m_cause <= '0; m_tval   <= '0;
    end else if (bus.csr_write_v_o) begin
      case (bus.csr_adr_wr_o)
        A_MSTATUS:  m_status  <= bus.csr_wdata_o;
        A_MTVEC:    m_tvec    <= bus.csr_wdata_o;
        A_MSCRATCH: m_scratch <= bus.csr_wdata_o;
        A_MEPC:     m_epc     <= bus.csr_wdata_o;
        A_MCAUSE:   m_cause   <= bus.csr_wdata_o;
        A_MTVAL:    m_tval    <= bus.csr_wdata_o;
        default:    ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_op(input logic [1:0] op, input logic [11:0] adr,
                        input logic [31:0] src, input logic [31:0] exp_old,
                        input logic exp_wr, input logic [31:0] exp_wdata);
    bus.csr_v_i   = 1'b1;
    bus.csr_op_i  = op;
    bus.csr_adr_i = adr;
    bus.csr_src_i = src;
    #1;
    chk("csr_ready", 32'(bus.ready_o), 32'd1);
    step();
    bus.csr_v_i = 1'b0;
    chk("csr_done", 32'(bus.csr_done_o), 32'd1);
    chk("csr_rdata", bus.csr_rdata_o, exp_old);
    chk("csr_wr_v", 32'(bus.csr_write_v_o), 32'(exp_wr));
    if (exp_wr) begin
      chk("csr_wr_adr", 32'(bus.csr_adr_wr_o), 32'(adr));
      chk("csr_wdata", bus.csr_wdata_o, exp_wdata);
    end
    step();
    chk("csr_done_end", 32'(bus.csr_done_o), 32'd0);
    chk("csr_ready_end", 32'(bus.ready_o), 32'd1);
    chk("csr_rdata_hold", bus.csr_rdata_o, exp_old);
  endtask

  task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc,
                         input logic [31:0] tval, input logic [31:0] exp_epc,
                         input logic [31:0] exp_status, input logic [31:0] exp_target);
    bus.trap_v_i     = 1'b1;
    bus.trap_cause_i = cause;
    bus.trap_pc_i    = pc;
    bus.trap_tval_i  = tval;
    #1;
    chk("trap_ready", 32'(bus.ready_o), 32'd1);
    step();
    bus.trap_v_i = 1'b0;
    chk("t_epc_ready", 32'(bus.ready_o), 32'd0);
    chk("t_epc_wv", 32'(bus.csr_write_v_o), 32'd1);
    chk("t_epc_adr", 32'(bus.csr_adr_wr_o), 32'(A_MEPC));
    chk("t_epc_data", bus.csr_wdata_o, exp_epc);
    step();
    chk("t_cause_adr", 32'(bus.csr_adr_wr_o), 32'(A_MCAUSE));
    chk("t_cause_data", bus.csr_wdata_o, cause);
    chk("t_cause_rd", 32'(bus.csr_adr_rd_o), 32'(A_MTVEC));
    step();
    chk("t_tval_adr", 32'(bus.csr_adr_wr_o), 32'(A_MTVAL));
    chk("t_tval_data", bus.csr_wdata_o, tval);
    step();
    chk("t_stat_adr", 32'(bus.csr_adr_wr_o), 32'(A_MSTATUS));
    chk("t_stat_data", bus.csr_wdata_o, exp_status);
    chk("t_stat_redir", 32'(bus.redirect_v_o), 32'd0);
    step();
    chk("t_redir_v", 32'(bus.redirect_v_o), 32'd1);
    chk("t_redir_pc", bus.redirect_pc_o, exp_target);
    chk("t_redir_wv", 32'(bus.csr_write_v_o), 32'd0);
    step();
    chk("t_end_redir", 32'(bus.redirect_v_o), 32'd0);
    chk("t_end_ready", 32'(bus.ready_o), 32'd1);
    chk("t_end_pc_hold", bus.redirect_pc_o, exp_target);
  endtask

  task automatic do_mret(input logic [31:0] exp_status, input logic [31:0] exp_target);
    bus.mret_v_i = 1'b1;
    #1;
    chk("mret_ready", 32'(bus.ready_o), 32'd1);
    step();
    bus.mret_v_i = 1'b0;
    chk("m_epc_ready", 32'(bus.ready_o), 32'd0);
    chk("m_epc_wv", 32'(bus.csr_write_v_o), 32'd0);
    chk("m_epc_rd", 32'(bus.csr_adr_rd_o), 32'(A_MEPC));
    step();
    chk("m_stat_ready", 32'(bus.ready_o), 32'd0);
    chk("m_stat_adr", 32'(bus.csr_adr_wr_o), 32'(A_MSTATUS));
    chk("m_stat_data", bus.csr_wdata_o, exp_status);
    step();
    chk("m_redir_ready", 32'(bus.ready_o), 32'd0);
    chk("m_redir_v", 32'(bus.redirect_v_o), 32'd1);
    chk("m_redir_pc", bus.redirect_pc_o, exp_target);
    chk("m_redir_wv", 32'(bus.csr_write_v_o), 32'd0);
    step();
    chk("m_end_redir", 32'(bus.redirect_v_o), 32'd0);
    chk("m_end_ready", 32'(bus.ready_o), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clr   = 1'b1;
    bus.csr_v_i = 1'b0; bus.csr_op_i = 2'b00; bus.csr_adr_i = '0; bus.csr_src_i = '0;
    bus.trap_v_i = 1'b0; bus.trap_cause_i = '0; bus.trap_pc_i = '0; bus.trap_tval_i = '0;
    bus.mret_v_i = 1'b0;
    step(); step();
    chk("rst_done", 32'(bus.csr_done_o), 32'd0);
    chk("rst_redir", 32'(bus.redirect_v_o), 32'd0);
    chk("rst_wv", 32'(bus.csr_write_v_o), 32'd0);
    chk("rst_rdata", bus.csr_rdata_o, 32'h0);
    chk("rst_pc", bus.redirect_pc_o, 32'h0);
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    reset = 1'b0;
    clr   = 1'b0;
    step();

    // CSR read-modify-write on MSCRATCH
    csr_op(OP_RW, A_MSCRATCH, 32'h5, 32'h0, 1'b1, 32'h5);
    csr_op(OP_RS, A_MSCRATCH, 32'hA, 32'h5, 1'b1, 32'hF);
    csr_op(OP_RC, A_MSCRATCH, 32'h3, 32'hF, 1'b1, 32'hC);
    csr_op(OP_RS, A_MSCRATCH, 32'h0, 32'hC, 1'b0, 32'h0);
    chk("mscratch_val", m_scratch, 32'hC);

    // Direct-mode trap
    csr_op(OP_RW, A_MTVEC, 32'h100, 32'h0, 1'b1, 32'h100);
    csr_op(OP_RW, A_MSTATUS, 32'h8, 32'h0, 1'b1, 32'h8);
    do_trap(32'h2, 32'h204, 32'hDEAD, 32'h204, 32'h1880, 32'h100);
    chk("mepc_t1", m_epc, 32'h204);
    chk("mcause_t1", m_cause, 32'h2);
    chk("mtval_t1", m_tval, 32'hDEAD);
    chk("mstatus_t1", m_status, 32'h1880);

    // Vectored mode: interrupt is offset, exception is not
    csr_op(OP_RW, A_MTVEC, 32'h101, 32'h100, 1'b1, 32'h101);
    do_trap(32'h80000007, 32'h300, 32'h0, 32'h300, 32'h1800, 32'h11C);
    do_trap(32'h7, 32'h207, 32'h0, 32'h204, 32'h1800, 32'h100);

    // MRET
    csr_op(OP_RW, A_MEPC, 32'h400, 32'h204, 1'b1, 32'h400);
    csr_op(OP_RW, A_MSTATUS, 32'h80, 32'h1800, 1'b1, 32'h80);
    do_mret(32'h1888, 32'h400);
    chk("mstatus_mret", m_status, 32'h1888);

    // All three requests at once: trap, then MRET, then CSR op
    bus.csr_v_i   = 1'b1;
    bus.csr_op_i  = OP_RW;
    bus.csr_adr_i = A_MSCRATCH;
    bus.csr_src_i = 32'h77;
    bus.mret_v_i  = 1'b1;
    do_trap(32'h3, 32'h500, 32'h11, 32'h500, 32'h1880, 32'h100);
    do_mret(32'h1888, 32'h500);
    csr_op(OP_RW, A_MSCRATCH, 32'h77, 32'hC, 1'b1, 32'h77);

    // Reset while in T_TVAL
    bus.trap_v_i     = 1'b1;
    bus.trap_cause_i = 32'h5;
    bus.trap_pc_i    = 32'h600;
    bus.trap_tval_i  = 32'hBEEF;
    step();
    bus.trap_v_i = 1'b0;
    step();
    step();
    chk("abort_in_tval", 32'(bus.csr_adr_wr_o), 32'(A_MTVAL));
    reset = 1'b1;
    #1;
    chk("abort_wv", 32'(bus.csr_write_v_o), 32'd0);
    chk("abort_redir", 32'(bus.redirect_v_o), 32'd0);
    chk("abort_done", 32'(bus.csr_done_o), 32'd0);
    chk("abort_rdata", bus.csr_rdata_o, 32'h0);
    chk("abort_pc", bus.redirect_pc_o, 32'h0);
    step();
    reset = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.ready_o), 32'd1);
    chk("abort_mepc", m_epc, 32'h600);
    chk("abort_mcause", m_cause, 32'h5);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_redir", 32'(bus.redirect_v_o), 32'd0);
    end
    chk("abort_mtval", m_tval, 32'h11);
    chk("abort_mstatus", m_status, 32'h1888);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
